uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter and sequencer that shares one `UART_Tx` serializer (12 MHz clock, CPB = 104) between two byte-stream requesters. It accepts bytes over valid/ready, presents each byte on the serializer's `i_data`, and pulses `nTx_EN` low to start transmission. It then waits for `o_RFN` before fetching the next byte. A grant is held for a whole packet, ends on the byte flagged `last`, and is released early by a watchdog if the serializer stops answering.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer benches.
// Holds the arbiter state encoding and a small one-hot helper.
package uart_pkg;

    localparam int UART_CPB_DEFAULT   = 104;
    localparam int UART_START_LOW_CYC = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        START,
        WAIT_RFN
    } uart_arb_state_t;

    // Index of a requester (0/1) to its one-hot grant vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: combinational winner from the valids and the
// priority pointer, which moves to the other requester on each advance strobe.
module rr_arb2
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       nRst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       owner,
    output logic [1:0] gnt
);

    logic rr_reg;

    // rr_reg names the requester that wins when both are asking.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rr_reg <= 1'b0;
        end else if (advance) begin
            rr_reg <= ~owner;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = idx_to_onehot(rr_reg);
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART_Tx serializer between two byte
// streams; a grant lasts a whole packet and a watchdog aborts it if o_RFN never returns.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CPB           = UART_CPB_DEFAULT,
    parameter int TIMEOUT_CYC   = 12 * CPB,
    parameter int START_LOW_CYC = UART_START_LOW_CYC
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_valid,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_valid,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic [7:0] o_tx_data,
    output logic       o_nTx_EN,
    input  logic       i_RFN,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SC_W = (START_LOW_CYC > 1) ? $clog2(START_LOW_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(START_LOW_CYC - 1);

    uart_arb_state_t state_reg, state_next;
    logic [1:0]      grant_reg, grant_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic            last_reg, last_next;
    logic            ntx_en_reg, ntx_en_next;
    logic [SC_W-1:0] start_cnt_reg, start_cnt_next;
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [7:0] req_data [2];
    logic [1:0] req_ready;
    logic [1:0] arb_gnt;
    logic       arb_advance;
    logic       owner;
    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       timeout_pulse;

    assign req_valid   = {i_req1_valid, i_req0_valid};
    assign req_last    = {i_req1_last, i_req0_last};
    assign req_data[0] = i_req0_data;
    assign req_data[1] = i_req1_data;

    // Only the granted requester ever sees ready, and only while fetching.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == FETCH) && grant_reg[gi];
        end
    endgenerate

    assign owner     = grant_reg[1];
    assign sel_valid = req_valid[owner];
    assign sel_last  = req_last[owner];
    assign sel_data  = req_data[owner];

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .nRst    (nRst),
        .req     (req_valid),
        .advance (arb_advance),
        .owner   (owner),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg     <= IDLE;
            grant_reg     <= 2'b00;
            tx_data_reg   <= 8'h00;
            last_reg      <= 1'b0;
            ntx_en_reg    <= 1'b1;
            start_cnt_reg <= '0;
            wd_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            tx_data_reg   <= tx_data_next;
            last_reg      <= last_next;
            ntx_en_reg    <= ntx_en_next;
            start_cnt_reg <= start_cnt_next;
            wd_cnt_reg    <= wd_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        tx_data_next   = tx_data_reg;
        last_next      = last_reg;
        ntx_en_next    = ntx_en_reg;
        start_cnt_next = start_cnt_reg;
        wd_cnt_next    = wd_cnt_reg;
        arb_advance    = 1'b0;
        timeout_pulse  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_next = arb_gnt;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // A stalled packet waits here indefinitely; the watchdog covers only the serializer.
                if (sel_valid) begin
                    tx_data_next   = sel_data;
                    last_next      = sel_last;
                    start_cnt_next = '0;
                    ntx_en_next    = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (start_cnt_reg == SC_LAST) begin
                    ntx_en_next = 1'b1;
                    wd_cnt_next = '0;
                    state_next  = WAIT_RFN;
                end else begin
                    start_cnt_next = start_cnt_reg + 1'b1;
                end
            end
            WAIT_RFN: begin
                // A late i_RFN landing on the timeout cycle still counts as success.
                if (i_RFN) begin
                    wd_cnt_next = '0;
                    if (last_reg) begin
                        grant_next  = 2'b00;
                        arb_advance = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (wd_cnt_reg == WD_LIMIT) begin
                    timeout_pulse = 1'b1;
                    wd_cnt_next   = '0;
                    grant_next    = 2'b00;
                    arb_advance   = 1'b1;
                    state_next    = IDLE;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    assign o_req0_ready = req_ready[0];
    assign o_req1_ready = req_ready[1];
    assign o_tx_data    = tx_data_reg;
    assign o_nTx_EN     = ntx_en_reg;
    assign o_grant      = grant_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_timeout    = timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run
// compared against an expected packet order built from the round-robin rules.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int TIMEOUT_CYC = 12 * UART_CPB_DEFAULT;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] i_req0_data, i_req1_data;
    logic       i_req0_valid, i_req1_valid;
    logic       i_req0_last, i_req1_last;
    logic       o_req0_ready, o_req1_ready;
    logic [7:0] o_tx_data;
    logic       o_nTx_EN;
    logic       i_RFN;
    logic [1:0] o_grant;
    logic       o_busy;
    logic       o_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk          (clk),
        .nRst         (nRst),
        .i_req0_data  (i_req0_data),
        .i_req0_valid (i_req0_valid),
        .i_req0_last  (i_req0_last),
        .o_req0_ready (o_req0_ready),
        .i_req1_data  (i_req1_data),
        .i_req1_valid (i_req1_valid),
        .i_req1_last  (i_req1_last),
        .o_req1_ready (o_req1_ready),
        .o_tx_data    (o_tx_data),
        .o_nTx_EN     (o_nTx_EN),
        .i_RFN        (i_RFN),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus queues hold {last, data}; logs hold {grant, data} per started byte.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] sent[$];
    logic [9:0] exp_q[$];
    int         rfn_log[$];

    int  cyc = 0;
    int  low_len = 0;
    int  wait_entry_cyc = 0;
    int  to_cnt = 0;
    int  to_cyc = 0;
    int  r1_first = 0;
    bit  prev_ntx = 1'b1;
    bit  fall_flag = 1'b0;
    bit  acc0 = 1'b0;
    bit  acc1 = 1'b0;
    bit  model_on = 1'b0;
    bit  stall_rand = 1'b0;
    bit  rfn_en = 1'b1;
    bit  rfn_rand = 1'b0;
    int  rfn_delay = 20;
    int  rfn_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(posedge clk);
        #2 nRst = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while ((o_busy || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, o_busy, 0);
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] g);
        int n = 0;
        while (o_grant !== g && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, o_grant, g);
    endtask

    // Requester drivers: present queue heads, pop on an accept seen at the previous negedge.
    initial begin
        i_req0_valid = 1'b0; i_req0_data = 8'h00; i_req0_last = 1'b0;
        i_req1_valid = 1'b0; i_req1_data = 8'h00; i_req1_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0 && !(stall_rand && o_grant[0] && $urandom_range(0, 3) == 0)) begin
                i_req0_valid = 1'b1;
                {i_req0_last, i_req0_data} = q0[0];
            end else begin
                i_req0_valid = 1'b0;
                i_req0_data  = 8'($urandom);
                i_req0_last  = 1'($urandom);
            end
            if (q1.size() > 0 && !(stall_rand && o_grant[1] && $urandom_range(0, 3) == 0)) begin
                i_req1_valid = 1'b1;
                {i_req1_last, i_req1_data} = q1[0];
            end else begin
                i_req1_valid = 1'b0;
                i_req1_data  = 8'($urandom);
                i_req1_last  = 1'($urandom);
            end
        end
    end

    // Serializer model: answers each start with one i_RFN pulse a set number of cycles later.
    initial begin
        i_RFN = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_RFN = 1'b0;
            if (!nRst) begin
                rfn_cnt   = 0;
                fall_flag = 1'b0;
            end else begin
                if (fall_flag) begin
                    fall_flag = 1'b0;
                    rfn_cnt = rfn_en ? (rfn_rand ? int'($urandom_range(3, 25)) : rfn_delay) : 0;
                end
                if (rfn_cnt > 0) begin
                    rfn_cnt--;
                    if (rfn_cnt == 0) i_RFN = 1'b1;
                end
            end
        end
    end

    // Monitor: logs byte starts, start-pulse widths, i_RFN and timeout events.
    initial begin
        logic [9:0] exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            acc0 = i_req0_valid && o_req0_ready;
            acc1 = i_req1_valid && o_req1_ready;
            if (i_RFN) rfn_log.push_back(cyc);
            if (o_req1_ready && r1_first == 0) r1_first = cyc;
            if (o_timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (!nRst) begin
                prev_ntx = 1'b1;
                low_len  = 0;
            end else begin
                if (prev_ntx && !o_nTx_EN) begin
                    low_len   = 1;
                    fall_flag = 1'b1;
                    sent.push_back({o_grant, o_tx_data});
                    if (model_on) begin
                        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                        $display("byte grant=%b data=%02h expected grant=%b data=%02h",
                                 o_grant, o_tx_data, exp_b[9:8], exp_b[7:0]);
                        chk("model_byte", {o_grant, o_tx_data}, exp_b);
                    end
                end else if (!prev_ntx && !o_nTx_EN) begin
                    low_len++;
                end else if (!prev_ntx && o_nTx_EN) begin
                    chk("start_low_len", low_len, UART_START_LOW_CYC);
                    wait_entry_cyc = cyc;
                end
                prev_ntx = o_nTx_EN;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] e;
        int         len;
        int         bad;
        int         n;
        int         to_before;

        // Reset values, sampled while reset is held.
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_ntx_en", o_nTx_EN, 1);
        chk("rst_tx_data", o_tx_data, 8'h00);
        chk("rst_busy", o_busy, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_ready", {o_req1_ready, o_req0_ready}, 2'b00);
        do_reset();

        // Single byte with exact latency, 1040-cycle serializer response.
        rfn_delay = 1040;
        @(posedge clk); #2;
        sent.delete();
        q0.push_back({1'b1, 8'h44});
        @(negedge clk);
        @(negedge clk); chk("t1_c0_grant", o_grant, 2'b00);
        @(negedge clk); chk("t1_c1_grant", o_grant, 2'b01);
        chk("t1_c1_ready", {o_req1_ready, o_req0_ready}, 2'b01);
        chk("t1_c1_ntx", o_nTx_EN, 1);
        @(negedge clk); chk("t1_c2_ntx", o_nTx_EN, 0); chk("t1_c2_data", o_tx_data, 8'h44);
        @(negedge clk); chk("t1_c3_ntx", o_nTx_EN, 0);
        @(negedge clk); chk("t1_c4_ntx", o_nTx_EN, 1); chk("t1_c4_busy", o_busy, 1);
        bad = 0; n = 0;
        while (o_busy && n < 3000) begin
            if (o_tx_data !== 8'h44 || o_grant !== 2'b01) bad++;
            @(negedge clk);
            n++;
        end
        chk("t1_hold", bad, 0);
        chk("t1_done", o_busy, 0);
        chk("t1_grant_end", o_grant, 2'b00);
        chk("t1_data_kept", o_tx_data, 8'h44);
        chk("t1_no_timeout", to_cnt, 0);

        // Packet hold: req1 must wait for the whole 3-byte req0 packet.
        rfn_delay = 30;
        @(posedge clk); #2;
        sent.delete(); rfn_log.delete(); r1_first = 0;
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        wait_grant("t2_grant0", 2'b01);
        @(posedge clk); #2;
        q1.push_back({1'b1, 8'h5A});
        wait_idle("t2_done", 5000);
        chk("t2_count", sent.size(), 4);
        chk("t2_b0", sent[0], {2'b01, 8'h41});
        chk("t2_b1", sent[1], {2'b01, 8'h42});
        chk("t2_b2", sent[2], {2'b01, 8'h43});
        chk("t2_b3", sent[3], {2'b10, 8'h5A});
        chk("t2_ready1_rise", r1_first, rfn_log[2] + 2);

        // Fairness from reset: continuous 1-byte packets alternate, req0 first.
        do_reset();
        rfn_delay = 15;
        @(posedge clk); #2;
        sent.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'(8'h10 + i)});
            q1.push_back({1'b1, 8'(8'h20 + i)});
        end
        wait_idle("t3_done", 2000);
        for (int i = 0; i < 8; i++) begin
            e = (i % 2 == 0) ? {2'b01, 8'(8'h10 + i / 2)} : {2'b10, 8'(8'h20 + i / 2)};
            chk($sformatf("t3_pkt%0d", i), sent[i], e);
        end

        // Watchdog: no i_RFN at all.
        rfn_en = 1'b0;
        to_cnt = 0;
        @(posedge clk); #2;
        q0.push_back({1'b1, 8'h77});
        wait_idle("t4_done", 3000);
        chk("t4_to_count", to_cnt, 1);
        chk("t4_to_delay", to_cyc - wait_entry_cyc, TIMEOUT_CYC);
        chk("t4_grant", o_grant, 2'b00);
        rfn_en = 1'b1;
        rfn_delay = 15;
        @(posedge clk); #2;
        sent.delete();
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h22});
        wait_idle("t4_rr_done", 2000);
        chk("t4_rr_first", sent[0], {2'b10, 8'h22});
        chk("t4_rr_second", sent[1], {2'b01, 8'h11});

        // i_RFN on the timeout cycle completes normally; one cycle later it times out.
        to_cnt = 0;
        rfn_delay = TIMEOUT_CYC + 2;
        @(posedge clk); #2;
        sent.delete();
        q0.push_back({1'b1, 8'h33});
        wait_idle("t4_same_done", 3000);
        chk("t4_same_no_to", to_cnt, 0);
        chk("t4_same_byte", sent[0], {2'b01, 8'h33});
        rfn_delay = TIMEOUT_CYC + 3;
        @(posedge clk); #2;
        q0.push_back({1'b1, 8'h34});
        wait_idle("t4_late_done", 3000);
        chk("t4_late_to", to_cnt, 1);

        // Stall in FETCH: no watchdog there.
        rfn_delay = 20;
        to_before = to_cnt;
        @(posedge clk); #2;
        sent.delete();
        q0.push_back({1'b0, 8'hA1});
        wait_grant("t5_grant", 2'b01);
        repeat (5100) @(negedge clk);
        chk("t5_busy", o_busy, 1);
        chk("t5_grant_held", o_grant, 2'b01);
        chk("t5_in_fetch", o_req0_ready, 1);
        chk("t5_no_to", to_cnt, to_before);
        @(posedge clk); #2;
        q0.push_back({1'b1, 8'hA2});
        wait_idle("t5_done", 2000);
        chk("t5_bytes", {sent[0], sent[1]}, {2'b01, 8'hA1, 2'b01, 8'hA2});

        // Asynchronous reset during START.
        @(posedge clk); #2;
        q1.push_back({1'b1, 8'hB3});
        n = 0;
        @(negedge clk);
        while (o_nTx_EN && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_start", o_nTx_EN, 0);
        #1 nRst = 1'b0;
        #1;
        chk("t6_ntx", o_nTx_EN, 1);
        chk("t6_grant", o_grant, 2'b00);
        chk("t6_busy", o_busy, 0);
        chk("t6_data", o_tx_data, 8'h00);
        chk("t6_ready", {o_req1_ready, o_req0_ready}, 2'b00);
        chk("t6_timeout", o_timeout, 0);
        repeat (2) @(posedge clk);
        #2 nRst = 1'b1;

        // Randomized packets: both requesters always pending, so packets strictly alternate.
        do_reset();
        @(posedge clk); #2;
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            for (int r = 0; r < 2; r++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    e[7:0] = 8'($urandom);
                    e[9:8] = (r == 0) ? 2'b01 : 2'b10;
                    exp_q.push_back(e);
                    if (r == 0) q0.push_back({(b == len - 1), e[7:0]});
                    else        q1.push_back({(b == len - 1), e[7:0]});
                end
            end
        end
        rfn_rand = 1'b1;
        stall_rand = 1'b1;
        model_on = 1'b1;
        wait_idle("rand_done", 20000);
        model_on = 1'b0;
        stall_rand = 1'b0;
        chk("rand_all_sent", exp_q.size(), 0);
        chk("rand_no_to", to_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
